main_bus_arbiter: RTL and testbench

MAIN_BUS_ARBITER -- requirements
Module: main_bus_arbiter

---
 rtl/main_bus_arbiter_if.sv | 24 ++
 rtl/main_bus_arbiter.sv | 140 ++++++++++++++
 tb/tb_main_bus_arbiter.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/main_bus_arbiter_if.sv
// Bus-side signal bundle for main_bus_arbiter: requester inputs and registered grant outputs.
// Handshake: bus_request is a level held by each requester; no ready exists, and a request is served once bus_grant shows its bit.
interface main_bus_arbiter_if #(
    parameter int N = 4
);
    localparam int IW = $clog2(N);

    logic          test_mode;
    logic [N-1:0]  bus_request;
    logic [N-1:0]  bus_grant;
    logic [IW-1:0] grant_id;
    logic          grant_valid;
    logic          timeout_pulse;

    modport master (
        output test_mode, bus_request,
        input  bus_grant, grant_id, grant_valid, timeout_pulse
    );

    modport slave (
        input  test_mode, bus_request,
        output bus_grant, grant_id, grant_valid, timeout_pulse
    );
endinterface

// File: rtl/main_bus_arbiter.sv
// Shared-bus arbiter: round-robin with tenure timeout, or fixed priority in test mode,
// with a one-cycle all-zero RELEASE gap between consecutive grants.
module main_bus_arbiter #(
    parameter int N          = 4,
    parameter int MAX_TENURE = 16
) (
    input  logic                clock,
    input  logic                reset,
    main_bus_arbiter_if.slave   bus,
    output logic [1:0]          state_dbg
);
    localparam int IW = $clog2(N);
    localparam int TW = $clog2(MAX_TENURE + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT   = 2'd1,
        S_RELEASE = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [IW-1:0] id_q, id_d;
    logic          valid_q, valid_d;
    logic          timeout_q, timeout_d;
    logic [TW-1:0] tenure_q, tenure_d;
    logic [IW-1:0] last_q, last_d;
    logic          armed_q;

    logic          pick_found;
    logic [IW-1:0] pick_idx;
    logic [IW-1:0] cand;
    logic          holder_req;
    logic          others_pending;
    logic          timeout_hit;
    logic          do_grant;

    // Winner selection; loops run high-to-low so the best candidate is written last.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        if (bus.test_mode) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (bus.bus_request[i]) begin
                    pick_found = 1'b1;
                    pick_idx   = IW'(i);
                end
            end
        end else begin
            for (int off = N; off >= 1; off--) begin
                cand = IW'((int'(last_q) + off) % N);
                if (bus.bus_request[cand]) begin
                    pick_found = 1'b1;
                    pick_idx   = cand;
                end
            end
        end
    end

    assign holder_req     = |(bus.bus_request & grant_q);
    assign others_pending = |(bus.bus_request & ~grant_q);
    assign timeout_hit    = !bus.test_mode && (tenure_q == TW'(MAX_TENURE)) && others_pending;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        id_d      = id_q;
        valid_d   = valid_q;
        timeout_d = 1'b0;
        tenure_d  = tenure_q;
        last_d    = last_q;
        do_grant  = 1'b0;

        case (state_q)
            S_IDLE: begin
                // armed_q holds off the very first edge after reset release
                if (armed_q && pick_found) do_grant = 1'b1;
            end
            S_GRANT: begin
                if (!holder_req || timeout_hit) begin
                    state_d   = S_RELEASE;
                    grant_d   = '0;
                    id_d      = '0;
                    valid_d   = 1'b0;
                    timeout_d = holder_req;
                end else if (tenure_q != TW'(MAX_TENURE)) begin
                    tenure_d = tenure_q + TW'(1);
                end
            end
            S_RELEASE: begin
                if (pick_found) do_grant = 1'b1;
                else            state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
                id_d    = '0;
                valid_d = 1'b0;
            end
        endcase

        if (do_grant) begin
            state_d  = S_GRANT;
            grant_d  = N'(1) << pick_idx;
            id_d     = pick_idx;
            valid_d  = 1'b1;
            tenure_d = TW'(1);
            last_d   = pick_idx;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            grant_q   <= '0;
            id_q      <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            tenure_q  <= '0;
            last_q    <= IW'(N - 1);
            armed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            id_q      <= id_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            tenure_q  <= tenure_d;
            last_q    <= last_d;
            armed_q   <= 1'b1;
        end
    end

    assign bus.bus_grant     = grant_q;
    assign bus.grant_id      = id_q;
    assign bus.grant_valid   = valid_q;
    assign bus.timeout_pulse = timeout_q;
    assign state_dbg         = state_q;
endmodule

// File: tb/tb_main_bus_arbiter.sv
// Directed bench for main_bus_arbiter: a per-cycle vector table plus hand-written
// sequences for reset, round-robin rotation, timeout, test mode and the sole requester.
module tb_main_bus_arbiter;
    localparam int N  = 4;
    localparam int MT = 16;

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] state_dbg;

    main_bus_arbiter_if #(.N(N)) bus_if ();

    main_bus_arbiter #(.N(N), .MAX_TENURE(MT)) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus_if),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] req;
        logic       mode;
        logic [3:0] grant;
        logic [1:0] id;
        logic       valid;
        logic       to;
    } vec_t;

    vec_t vecs[15];
    logic [1:0] exp_q[$];

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic start_reset(input logic [3:0] req, input logic mode);
        reset = 1'b1;
        bus_if.bus_request = req;
        bus_if.test_mode   = mode;
        step();
        reset = 1'b0;
    endtask

    // ---------------- stimulus / scoreboard ----------------
    initial begin
        int held;
        int bad;
        int ngr;
        int hold;
        int gap;
        logic prev_valid;
        logic [1:0] cur_id;
        logic [1:0] e;

        vecs[0]  = '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
        vecs[1]  = '{4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
        vecs[2]  = '{4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
        vecs[3]  = '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
        vecs[4]  = '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
        vecs[5]  = '{4'b1010, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0};
        vecs[6]  = '{4'b0010, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
        vecs[7]  = '{4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
        vecs[8]  = '{4'b0011, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0};
        vecs[9]  = '{4'b0101, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
        vecs[10] = '{4'b0101, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0};
        vecs[11] = '{4'b0100, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
        vecs[12] = '{4'b0110, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
        vecs[13] = '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
        vecs[14] = '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};

        // Reset values and the two-edge guard before the first grant
        reset = 1'b1;
        bus_if.bus_request = 4'b0100;
        bus_if.test_mode   = 1'b0;
        #12;
        check("rst_grant", bus_if.bus_grant, 4'b0000);
        check("rst_id", bus_if.grant_id, 2'd0);
        check("rst_valid", bus_if.grant_valid, 1'b0);
        check("rst_timeout", bus_if.timeout_pulse, 1'b0);
        check("rst_state", state_dbg, 2'd0);
        step();
        reset = 1'b0;
        step();
        check("first_edge_no_grant", bus_if.bus_grant, 4'b0000);
        step();
        check("req2_grant", bus_if.bus_grant, 4'b0100);
        check("req2_id", bus_if.grant_id, 2'd2);
        check("req2_valid", bus_if.grant_valid, 1'b1);
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (bus_if.bus_grant !== 4'b0100) bad++;
        end
        check("req2_hold_bad_cycles", bad, 0);

        // Vector table, starting from an armed IDLE
        start_reset(4'b0000, 1'b0);
        step();
        for (int i = 0; i < 15; i++) begin
            bus_if.bus_request = vecs[i].req;
            bus_if.test_mode   = vecs[i].mode;
            step();
            check($sformatf("vec%0d_grant", i), bus_if.bus_grant, vecs[i].grant);
            check($sformatf("vec%0d_id", i), bus_if.grant_id, vecs[i].id);
            check($sformatf("vec%0d_valid", i), bus_if.grant_valid, vecs[i].valid);
            check($sformatf("vec%0d_timeout", i), bus_if.timeout_pulse, vecs[i].to);
        end

        // Asynchronous reset mid-grant, then requester 0 first
        start_reset(4'b0010, 1'b0);
        step();
        step();
        check("pre_rst_grant", bus_if.bus_grant, 4'b0010);
        #3;
        reset = 1'b1;
        #1;
        check("async_rst_grant", bus_if.bus_grant, 4'b0000);
        check("async_rst_valid", bus_if.grant_valid, 1'b0);
        check("async_rst_state", state_dbg, 2'd0);
        bus_if.bus_request = 4'b0011;
        step();
        reset = 1'b0;
        step();
        check("post_rst_first_edge", bus_if.bus_grant, 4'b0000);
        step();
        check("post_rst_grant", bus_if.bus_grant, 4'b0001);

        // Round-robin rotation with 3-cycle holds
        exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        start_reset(4'b1111, 1'b0);
        ngr = 0; hold = 0; gap = 0; prev_valid = 1'b0; cur_id = '0;
        for (int c = 0; c < 80 && ngr < 5; c++) begin
            step();
            if (bus_if.grant_valid) begin
                if (!prev_valid) begin
                    if (ngr > 0) check("rr_gap", gap, 1);
                    e = exp_q.pop_front();
                    check("rr_order", bus_if.grant_id, e);
                    check("rr_onehot", bus_if.bus_grant, 4'b0001 << e);
                    cur_id = e;
                    ngr++;
                    hold = 0;
                end else begin
                    check("rr_stable_id", bus_if.grant_id, cur_id);
                end
                hold++;
                if (hold == 3) bus_if.bus_request = 4'b1111 & ~(4'b0001 << cur_id);
                gap = 0;
            end else begin
                gap++;
                bus_if.bus_request = 4'b1111;
            end
            prev_valid = bus_if.grant_valid;
        end
        check("rr_grants_seen", ngr, 5);

        // Tenure timeout: holder 1 revoked after MT cycles, requester 3 next
        start_reset(4'b1010, 1'b0);
        step();
        step();
        held = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus_if.bus_grant !== 4'b0010 || bus_if.timeout_pulse !== 1'b0) break;
            held++;
            step();
        end
        check("to_tenure_cycles", held, MT);
        check("to_release_grant", bus_if.bus_grant, 4'b0000);
        check("to_pulse", bus_if.timeout_pulse, 1'b1);
        check("to_release_state", state_dbg, 2'd2);
        step();
        check("to_next_grant", bus_if.bus_grant, 4'b1000);
        check("to_next_id", bus_if.grant_id, 2'd3);
        check("to_pulse_cleared", bus_if.timeout_pulse, 1'b0);

        // Same stimulus in test mode: no timeout, then lowest index wins
        start_reset(4'b1010, 1'b1);
        step();
        step();
        check("tm_grant", bus_if.bus_grant, 4'b0010);
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (bus_if.bus_grant !== 4'b0010 || bus_if.timeout_pulse !== 1'b0) bad++;
        end
        check("tm_hold_bad_cycles", bad, 0);
        bus_if.bus_request = 4'b1001;
        step();
        check("tm_release", bus_if.bus_grant, 4'b0000);
        step();
        check("tm_lowest_wins", bus_if.bus_grant, 4'b0001);

        // Sole requester with mid-cycle glitches: never timed out
        start_reset(4'b0001, 1'b0);
        step();
        step();
        check("sole_grant", bus_if.bus_grant, 4'b0001);
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            #2 bus_if.bus_request = 4'b0000;
            #2 bus_if.bus_request = 4'b0001;
            step();
            if (bus_if.bus_grant !== 4'b0001 || bus_if.timeout_pulse !== 1'b0) bad++;
        end
        check("sole_bad_cycles", bad, 0);
        // Saturated tenure: a late second requester triggers an immediate revoke
        bus_if.bus_request = 4'b0011;
        step();
        check("sat_pulse", bus_if.timeout_pulse, 1'b1);
        check("sat_release", bus_if.bus_grant, 4'b0000);
        step();
        check("sat_next_grant", bus_if.bus_grant, 4'b0010);

        // ---------------- report ----------------
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
